// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the 3x3 systolic array sequencer: state encoding,
// array geometry and operand element-index helpers.
package sa_ctrl_pkg;

  localparam int SA_N        = 3;
  localparam int NUM_PE      = SA_N * SA_N;
  localparam int FEED_CYCLES = 2 * SA_N + 1;
  localparam int CNT_W       = 3;

  localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(FEED_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // A lane carries real data only while t-lane falls inside 0..SA_N-1.
  function automatic logic lane_active(input logic [CNT_W-1:0] t, input int lane);
    int k;
    k = int'(t) - lane;
    return (k >= 32'sd0) && (k < SA_N);
  endfunction

  // Row lane i at step t presents A[i][t-i]: flat index 3i + (t-i) = t + 2i.
  function automatic logic [3:0] row_elem(input logic [CNT_W-1:0] t, input int lane);
    return 4'(int'(t) + 2 * lane);
  endfunction

  // Column lane j at step t presents B[t-j][j]: flat index 3(t-j) + j = 3t - 2j.
  function automatic logic [3:0] col_elem(input logic [CNT_W-1:0] t, input int lane);
    return 4'(3 * int'(t) - 2 * lane);
  endfunction

endpackage

// File: rtl/sa_skew_feeder.sv
// Skewed operand selection: picks the diagonal wavefront of A and B for the
// current feed step, driving zero outside each lane's valid window.
module sa_skew_feeder
  import sa_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [NUM_PE*DW-1:0] a_lat,
  input  logic [NUM_PE*DW-1:0] b_lat,
  input  logic                 feed_en,
  input  logic [CNT_W-1:0]     t,
  output logic [DW-1:0]        sa_a1,
  output logic [DW-1:0]        sa_a2,
  output logic [DW-1:0]        sa_a3,
  output logic [DW-1:0]        sa_b1,
  output logic [DW-1:0]        sa_b2,
  output logic [DW-1:0]        sa_b3
);

  logic [DW-1:0] a_el   [NUM_PE];
  logic [DW-1:0] b_el   [NUM_PE];
  logic [DW-1:0] row_op [SA_N];
  logic [DW-1:0] col_op [SA_N];

  for (genvar e = 0; e < NUM_PE; e++) begin : g_unpack
    assign a_el[e] = a_lat[e*DW +: DW];
    assign b_el[e] = b_lat[e*DW +: DW];
  end

  // Select each lane's element for step t, zero when the lane is idle.
  always_comb begin
    for (int lane = 0; lane < SA_N; lane++) begin
      if (feed_en && lane_active(t, lane)) begin
        row_op[lane] = a_el[row_elem(t, lane)];
        col_op[lane] = b_el[col_elem(t, lane)];
      end else begin
        row_op[lane] = {DW{1'b0}};
        col_op[lane] = {DW{1'b0}};
      end
    end
  end

  assign sa_a1 = row_op[0];
  assign sa_a2 = row_op[1];
  assign sa_a3 = row_op[2];
  assign sa_b1 = col_op[0];
  assign sa_b2 = col_op[1];
  assign sa_b3 = col_op[2];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 3x3 output-stationary MAC array: latches operands on
// start, clears the array, feeds skewed operands, drains, captures results.
module systolic_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MAC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_PE*DW-1:0] a_mat,
  input  logic [NUM_PE*DW-1:0] b_mat,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PE*DW-1:0] c_mat,
  output logic                 sa_clr_n,
  output logic [DW-1:0]        sa_a1,
  output logic [DW-1:0]        sa_a2,
  output logic [DW-1:0]        sa_a3,
  output logic [DW-1:0]        sa_b1,
  output logic [DW-1:0]        sa_b2,
  output logic [DW-1:0]        sa_b3,
  input  logic [DW-1:0]        sa_c1,
  input  logic [DW-1:0]        sa_c2,
  input  logic [DW-1:0]        sa_c3,
  input  logic [DW-1:0]        sa_c4,
  input  logic [DW-1:0]        sa_c5,
  input  logic [DW-1:0]        sa_c6,
  input  logic [DW-1:0]        sa_c7,
  input  logic [DW-1:0]        sa_c8,
  input  logic [DW-1:0]        sa_c9
);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LAT - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_PE*DW-1:0] a_lat;
  logic [NUM_PE*DW-1:0] b_lat;

  // Job sequencer: state, step counter, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= {CNT_W{1'b0}};
      a_lat    <= {(NUM_PE*DW){1'b0}};
      b_lat    <= {(NUM_PE*DW){1'b0}};
      c_mat    <= {(NUM_PE*DW){1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      sa_clr_n <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          cnt  <= {CNT_W{1'b0}};
          if (start) begin
            a_lat    <= a_mat;
            b_lat    <= b_mat;
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            sa_clr_n <= 1'b0;
          end else begin
            busy     <= 1'b0;
            sa_clr_n <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state    <= ST_FEED;
          sa_clr_n <= 1'b1;
          cnt      <= {CNT_W{1'b0}};
        end
        ST_FEED: begin
          if (cnt == FEED_LAST) begin
            state <= ST_DRAIN;
            cnt   <= {CNT_W{1'b0}};
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= ST_CAPTURE;
            cnt   <= {CNT_W{1'b0}};
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_CAPTURE: begin
          c_mat <= {sa_c9, sa_c8, sa_c7, sa_c6, sa_c5, sa_c4, sa_c3, sa_c2, sa_c1};
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= {CNT_W{1'b0}};
          busy     <= 1'b0;
          done     <= 1'b0;
          sa_clr_n <= 1'b1;
        end
      endcase
    end
  end

  sa_skew_feeder #(.DW(DW)) u_feeder (
    .a_lat   (a_lat),
    .b_lat   (b_lat),
    .feed_en (state == ST_FEED),
    .t       (cnt),
    .sa_a1   (sa_a1),
    .sa_a2   (sa_a2),
    .sa_a3   (sa_a3),
    .sa_b1   (sa_b1),
    .sa_b2   (sa_b2),
    .sa_b3   (sa_b3)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a behavioural 3x3 output-stationary MAC array
// closes the loop; expected results go into a scoreboard queue at start time
// and a monitor pops and compares them on every done pulse.
module tb_systolic_ctrl;

  localparam int DW = 32;
  localparam int MW = 9 * DW;

  typedef struct {
    logic [MW-1:0] c;
    int            at;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [MW-1:0] a_mat;
  logic [MW-1:0] b_mat;
  logic          busy;
  logic          done;
  logic [MW-1:0] c_mat;
  logic          sa_clr_n;
  logic [DW-1:0] sa_a1, sa_a2, sa_a3, sa_b1, sa_b2, sa_b3;
  logic [DW-1:0] acc  [3][3];
  logic [DW-1:0] areg [3][3];
  logic [DW-1:0] breg [3][3];
  logic [DW-1:0] ain  [3][3];
  logic [DW-1:0] bin  [3][3];
  logic [DW-1:0] sa_a_v [3];
  logic [DW-1:0] sa_b_v [3];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  exp_t sb_q [$];
  exp_t mon_e;

  systolic_ctrl #(.DW(DW), .MAC_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .b_mat(b_mat),
    .busy(busy), .done(done), .c_mat(c_mat), .sa_clr_n(sa_clr_n),
    .sa_a1(sa_a1), .sa_a2(sa_a2), .sa_a3(sa_a3),
    .sa_b1(sa_b1), .sa_b2(sa_b2), .sa_b3(sa_b3),
    .sa_c1(acc[0][0]), .sa_c2(acc[0][1]), .sa_c3(acc[0][2]),
    .sa_c4(acc[1][0]), .sa_c5(acc[1][1]), .sa_c6(acc[1][2]),
    .sa_c7(acc[2][0]), .sa_c8(acc[2][1]), .sa_c9(acc[2][2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to timestamp done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: operands hop one PE per cycle, each PE accumulates a*b.
  assign sa_a_v[0] = sa_a1;
  assign sa_a_v[1] = sa_a2;
  assign sa_a_v[2] = sa_a3;
  assign sa_b_v[0] = sa_b1;
  assign sa_b_v[1] = sa_b2;
  assign sa_b_v[2] = sa_b3;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ain[i][j] = (j == 0) ? sa_a_v[i] : areg[i][(j > 0) ? (j - 1) : 0];
        bin[i][j] = (i == 0) ? sa_b_v[j] : breg[(i > 0) ? (i - 1) : 0][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!sa_clr_n) begin
          acc[i][j]  <= '0;
          areg[i][j] <= '0;
          breg[i][j] <= '0;
        end else begin
          acc[i][j]  <= acc[i][j] + ain[i][j] * bin[i][j];
          areg[i][j] <= ain[i][j];
          breg[i][j] <= bin[i][j];
        end
      end
    end
  end

  task automatic chkw(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (rst && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got done=1 at cyc %0d want no done", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chkw("c_mat", c_mat, mon_e.c);
        chki("done_cycle", cyc, mon_e.at);
      end
    end
  end

  function automatic logic [MW-1:0] mat(input logic [31:0] e0, e1, e2, e3, e4,
                                        e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [MW-1:0] fill(input logic [31:0] v);
    return {9{v}};
  endfunction

  // Operand bus expected when both matrices are filled with v, k cycles after start.
  function automatic logic [MW-1:0] exp_ops(input int k, input logic [31:0] v);
    logic [31:0] a [3];
    int t;
    t = k - 2;
    for (int i = 0; i < 3; i++) begin
      a[i] = (t >= 0 && t <= 6 && t - i >= 0 && t - i <= 2) ? v : 32'd0;
    end
    return {96'd0, a[0], a[1], a[2], a[0], a[1], a[2]};
  endfunction

  function automatic logic [MW-1:0] ops_now();
    return {96'd0, sa_a1, sa_a2, sa_a3, sa_b1, sa_b2, sa_b3};
  endfunction

  // Issue a start at a negedge while idle, register the expected result.
  task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input logic [MW-1:0] c, output int s);
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    s     = cyc;
    sb_q.push_back('{c: c, at: s + 11});
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [MW-1:0] id_m, seq_m, three_m, c27_m, twoi_m, seq2_m, ff_m;
  int s;
  int k;

  initial begin
    id_m    = mat(32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1);
    seq_m   = mat(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9);
    twoi_m  = mat(32'd2, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd2);
    seq2_m  = mat(32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12, 32'd14, 32'd16, 32'd18);
    three_m = fill(32'd3);
    c27_m   = fill(32'd27);
    ff_m    = fill(32'hFFFF_FFFF);

    rst = 1'b1; start = 1'b0; a_mat = '0; b_mat = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_clr_n", sa_clr_n, 1'b0);
    chkw("rst_c_mat", c_mat, '0);
    chkw("rst_ops", ops_now(), '0);
    rst = 1'b1;
    @(negedge clk);
    chk1("idle_clr_n", sa_clr_n, 1'b1);
    chk1("idle_busy", busy, 1'b0);

    // Identity x [1..9], busy window.
    launch(id_m, seq_m, seq_m, s);
    for (int n = 0; n < 12; n++) begin
      k = cyc - s;
      chk1("busy_window", busy, (k >= 1 && k <= 11));
      @(negedge clk);
    end
    chki("t1_done_count", done_seen, 1);
    chki("t1_queue", sb_q.size(), 0);

    // All threes, operand skew trace and clear pulse.
    launch(three_m, three_m, c27_m, s);
    for (int n = 0; n < 12; n++) begin
      k = cyc - s;
      chkw("skew_ops", ops_now(), exp_ops(k, 32'd3));
      chk1("clr_n_trace", sa_clr_n, (k != 1));
      @(negedge clk);
    end
    chki("t3_done_count", done_seen, 2);
    chki("t3_queue", sb_q.size(), 0);

    // Start held high: back-to-back jobs, first result held until second capture.
    a_mat = seq_m; b_mat = id_m; start = 1'b1; s = cyc;
    sb_q.push_back('{c: seq_m, at: s + 11});
    @(negedge clk);
    a_mat = twoi_m; b_mat = seq_m;
    sb_q.push_back('{c: seq2_m, at: s + 23});
    for (int n = 0; n < 25; n++) begin
      k = cyc - s;
      if (k == 13) start = 1'b0;
      if (k >= 12 && k <= 22) chkw("c_mat_hold", c_mat, seq_m);
      @(negedge clk);
    end
    start = 1'b0;
    chki("t4_done_count", done_seen, 4);
    chki("t4_queue", sb_q.size(), 0);

    // Start pulse and operand change mid-job are ignored.
    launch(seq_m, id_m, seq_m, s);
    for (int n = 0; n < 20; n++) begin
      k = cyc - s;
      if (k == 4) begin
        start = 1'b1;
        a_mat = three_m;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chki("t5_done_count", done_seen, 5);
    chki("t5_queue", sb_q.size(), 0);

    // Asynchronous reset during feed step t=3 aborts the job.
    launch(three_m, three_m, c27_m, s);
    while (cyc - s < 5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_clr_n", sa_clr_n, 1'b0);
    chkw("abort_c_mat", c_mat, '0);
    chkw("abort_ops", ops_now(), '0);
    void'(sb_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chki("abort_no_done", done_seen, 5);
    chkw("abort_c_mat_held", c_mat, '0);
    launch(seq_m, id_m, seq_m, s);
    repeat (13) @(negedge clk);
    chki("t6_done_count", done_seen, 6);
    chki("t6_queue", sb_q.size(), 0);

    // All-ones operands forwarded unaltered; array sum wraps to 3.
    launch(ff_m, ff_m, three_m, s);
    for (int n = 0; n < 13; n++) begin
      k = cyc - s;
      chkw("ff_ops", ops_now(), exp_ops(k, 32'hFFFF_FFFF));
      @(negedge clk);
    end
    chki("t7_done_count", done_seen, 7);
    chki("t7_queue", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the 3x3 output-stationary systolic MAC array (PEs 1..9, row-major).
- Accepts a start request with two 3x3 operand matrices and clears the array accumulators.
- Drives the skewed row operands (a1..a3) and column operands (b1..b3), waits for the pipeline to drain, then captures the nine accumulator results into a holding register and signals done.
- Sits between the host/DMA-side register file and the array.

Parameters:
- DW, 32, operand/result element width (matches array data_size)
- MAC_LAT, 1, cycles from the last operand entering a PE to its out_c being valid; range 1..7

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low
- start  in  1  request; sampled only in IDLE
- a_mat  in  9*DW  matrix A, element A[i][k] at bits [(3i+k)*DW +: DW]
- b_mat  in  9*DW  matrix B, element B[k][j] at bits [(3k+j)*DW +: DW]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when c_mat is updated
- c_mat  out  9*DW  registered result, C[i][j] at bits [(3i+j)*DW +: DW]
- sa_clr_n  out  1  active-low clear to all MAC accumulators/pipes
- sa_a1..sa_a3  out  DW each  row operands to PE1/PE4/PE7 in_a
- sa_b1..sa_b3  out  DW each  column operands to PE1/PE2/PE3 in_b
- sa_c1..sa_c9  in  DW each  PE accumulator outputs

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, c_mat=0, sa_clr_n=0, sa_a*/sa_b*=0, operand latches=0, feed counter=0.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> CAPTURE -> DONE -> IDLE.
- IDLE: sa_clr_n=1, operand outputs 0. If start=1 at the edge, latch a_mat/b_mat into internal registers and go to CLEAR. Later changes on a_mat/b_mat are ignored until the next accepted start.
- CLEAR (1 cycle): sa_clr_n=0, operand outputs 0.
- FEED (7 cycles, counter t=0..6): sa_clr_n=1.
  - sa_a(i+1) = A[i][t-i] if 0<=t-i<=2, else 0.
  - sa_b(j+1) = B[t-j][j] if 0<=t-j<=2, else 0.
  - Values are held for the whole cycle t; they come from registered state/counter only, with no combinational path from start.
- DRAIN (MAC_LAT cycles): operand outputs 0, sa_clr_n=1.
- CAPTURE (1 cycle): c_mat <= {sa_c9..sa_c1} at the end of the cycle.
- DONE (1 cycle): done=1, busy=1. start is ignored here and is accepted again in the following IDLE cycle.
- Latency, with the start edge as cycle 0: CLEAR=1, FEED=2..8, DRAIN=9..8+MAC_LAT, CAPTURE=9+MAC_LAT, done high in cycle 10+MAC_LAT (11 at default).
- start while busy: ignored, no queuing, no error.
- c_mat holds its value until the next CAPTURE; it is not cleared by CLEAR.
- Arithmetic is owned by the MACs; the controller only forwards DW-bit values unchanged. Results wrap modulo 2^DW as produced by the array.
- Reset mid-operation: immediate return to IDLE with all reset values, including c_mat=0. No done pulse is produced for the aborted job.

Decomposition:
- Shared package sa_ctrl_pkg:
  - state encoding (IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE)
  - SA_N=3, FEED_CYCLES=2*SA_N+1=7
  - element index helper constants
- One sub-module, sa_skew_feeder: combinational selection of sa_a1..3/sa_b1..3 from the latched matrices and the feed counter, zero outside the valid window.

Test Plan:
- A=identity, B=[1..9] row-major, one start -> done exactly once in cycle 11, c_mat=[1..9], busy high in cycles 1..11.
- A=B=all 3s -> every C element =27. Operand-output trace matches the skew table: sa_a3 nonzero only in FEED t=2..4, sa_b1 only in t=0..2.
- Two jobs: start held high continuously -> second job accepted in the first IDLE cycle after DONE; second c_mat correct; first c_mat stable until the second CAPTURE.
- start pulsed in FEED, and a_mat changed mid-job -> both ignored; result reflects the originally latched operands; exactly one done.
- rst=0 asserted during FEED t=3 -> outputs reach reset values asynchronously, c_mat=0, no done. The next start yields a correct result, A=[1..9] x identity = [1..9].
- All elements 0xFFFFFFFF (DW=32) -> C elements equal the array's wrapped sum, 3 mod 2^32 = 0x00000003. Controller forwards values unaltered.
